// File: rtl/dmem_pkg.sv
// dmem_pkg: width codes, FSM states and request check helpers shared by the dmem responder.
package dmem_pkg;
    localparam logic [1:0] DIGIT_B = 2'b00;
    localparam logic [1:0] DIGIT_H = 2'b01;
    localparam logic [1:0] DIGIT_W = 2'b10;
    typedef enum logic [1:0] {IDLE, BUSY, COMMIT, RESP} state_t;
    function automatic logic WIDTH_ERR(input logic [1:0] digit, input logic [1:0] lo);
        return !(digit == DIGIT_B || (digit == DIGIT_H && !lo[0]) || (digit == DIGIT_W && lo == 2'b00));
    endfunction
    function automatic logic ADDR_ERR(input logic [31:0] addr, input int unsigned depth);
        return {2'b00, addr[31:2]} >= depth;
    endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response handshake between the core load/store path and the data memory.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_digit;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (output req_valid, req_wr, req_digit, req_sign, req_addr, req_wdata,
                    input req_ready, resp_valid, resp_rdata, resp_err);
    modport slave (input req_valid, req_wr, req_digit, req_sign, req_addr, req_wdata,
                   output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian byte-lane enables, store replication and load extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  lo,
    input  logic [1:0]  digit,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);
    logic [31:0] sh;
    // Store data is replicated across all lanes so the byte enables alone pick the target bytes.
    always_comb begin
        sh = rword >> {lo, 3'b000};
        be = digit == DIGIT_B ? 4'b0001 << lo :
             digit == DIGIT_H ? (lo[1] ? 4'b1100 : 4'b0011) :
             digit == DIGIT_W ? 4'b1111 : 4'b0000;
        wword = digit == DIGIT_B ? {4{wdata[7:0]}} : digit == DIGIT_H ? {2{wdata[15:0]}} : wdata;
        rdata = digit == DIGIT_B ? {{24{sign & sh[7]}}, sh[7:0]} :
                digit == DIGIT_H ? {{16{sign & sh[15]}}, sh[15:0]} : rword;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time wait-state data memory with registered single-cycle response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    // BUSY spans WAIT_CYCLES cycles, so the counter starts one below and exits at zero.
    localparam logic [3:0] CNT_INIT = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        l_wr, l_sign, err, accept;
    logic [1:0]  l_digit;
    logic [31:0] l_addr, l_wdata, wword, rdata;
    logic [3:0]  be;
    logic [31:0] mem [DEPTH_WORDS];
    assign accept = bus.req_valid && bus.req_ready;
    assign bus.req_ready = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign err = WIDTH_ERR(l_digit, l_addr[1:0]) || ADDR_ERR(l_addr, DEPTH_WORDS);
    dmem_lane_align u_align (
        .lo    (l_addr[1:0]),
        .digit (l_digit),
        .sign  (l_sign),
        .wdata (l_wdata),
        .rword (mem[l_addr[AW+1:2]]),
        .be    (be),
        .wword (wword),
        .rdata (rdata)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (WAIT_CYCLES == 0 ? COMMIT : BUSY) : IDLE;
            BUSY:    state_nx = cnt == 4'd0 ? COMMIT : BUSY;
            COMMIT:  state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            l_wr           <= 1'b0;
            l_sign         <= 1'b0;
            l_digit        <= 2'b00;
            l_addr         <= 32'd0;
            l_wdata        <= 32'd0;
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt     <= CNT_INIT;
                l_wr    <= bus.req_wr;
                l_sign  <= bus.req_sign;
                l_digit <= bus.req_digit;
                l_addr  <= bus.req_addr;
                l_wdata <= bus.req_wdata;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == COMMIT) begin
                bus.resp_rdata <= (err || l_wr) ? 32'd0 : rdata;
                bus.resp_err   <= err;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (state == COMMIT && l_wr && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[l_addr[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed requests checked against a byte-array memory model and literal expectations.
module tb_dmem_responder;
    import dmem_pkg::*;
    localparam int DEPTH = 256;
    localparam int WAIT = 2;
    typedef struct packed {
        int          due;
        logic        wr;
        logic [1:0]  dg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        e;
    } pend_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    pend_t pq[$];
    pend_t mp;
    logic mev;
    logic [7:0] mm [4*DEPTH];
    logic [32:0] log_q[$];
    always #5 clk = ~clk;
    dmem_if bus ();
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask
    // Expected response straight from the access rules, computed on the byte model.
    function automatic pend_t model(input logic wr, input logic [1:0] dg, input logic sg,
                                    input logic [31:0] a, input logic [31:0] wd);
        pend_t p;
        int n;
        logic [31:0] v;
        n = 1 << dg;
        v = 32'd0;
        p.due = 0;
        p.wr = wr;
        p.dg = dg;
        p.a = a;
        p.wd = wd;
        p.e = dg == 2'b11 || a % n != 0 || a / 4 >= DEPTH;
        if (!p.e && !wr) begin
            for (int i = 0; i < n; i++) v |= 32'(mm[a + i]) << (8 * i);
            if (sg && n < 4 && v[8*n-1]) v |= ~32'd0 << (8 * n);
        end
        p.rd = (p.e || wr) ? 32'd0 : v;
        return p;
    endfunction
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst) begin
            pq.delete();
            chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
            chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        end else begin
            chk("req_ready", 32'(bus.req_ready), 32'(pq.size() == 0));
            mev = pq.size() > 0 && pq[0].due == cyc;
            chk("resp_valid", 32'(bus.resp_valid), 32'(mev));
            if (mev) begin
                mp = pq.pop_front();
                chk($sformatf("resp_rdata@%h", mp.a), bus.resp_rdata, mp.rd);
                chk($sformatf("resp_err@%h", mp.a), 32'(bus.resp_err), 32'(mp.e));
                if (mp.wr && !mp.e)
                    for (int i = 0; i < (1 << mp.dg); i++) mm[mp.a + i] = mp.wd[8*i +: 8];
            end
            if (bus.resp_valid) log_q.push_back({bus.resp_err, bus.resp_rdata});
            if (bus.req_valid && bus.req_ready) begin
                mp = model(bus.req_wr, bus.req_digit, bus.req_sign, bus.req_addr, bus.req_wdata);
                mp.due = cyc + WAIT + 2;
                pq.push_back(mp);
            end
        end
    end
    task automatic issue(input logic wr, input logic [1:0] dg, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        logic ok;
        bus.req_wr = wr;
        bus.req_digit = dg;
        bus.req_sign = sg;
        bus.req_addr = a;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bus.req_ready;
        end
        chk($sformatf("accept@%h", a), 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask
    task automatic xact(input logic wr, input logic [1:0] dg, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee);
        logic ok;
        issue(wr, dg, sg, a, wd);
        bus.req_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = bus.resp_valid;
        end
        chk($sformatf("resp_seen@%h", a), 32'(ok), 32'd1);
        if (ok) begin
            chk($sformatf("lit_rdata@%h", a), bus.resp_rdata, er);
            chk($sformatf("lit_err@%h", a), 32'(bus.resp_err), 32'(ee));
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_wr = 1'b0;
        bus.req_digit = 2'b00;
        bus.req_sign = 1'b0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        xact(1'b1, DIGIT_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xact(1'b0, DIGIT_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        xact(1'b1, DIGIT_W, 1'b0, 32'h20, 32'h80FF7F01, 32'h0, 1'b0);
        xact(1'b0, DIGIT_B, 1'b1, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0);
        xact(1'b0, DIGIT_B, 1'b0, 32'h23, 32'h0, 32'h00000080, 1'b0);
        xact(1'b0, DIGIT_H, 1'b1, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0);
        xact(1'b0, DIGIT_B, 1'b1, 32'h20, 32'h0, 32'h00000001, 1'b0);
        xact(1'b0, DIGIT_H, 1'b0, 32'h22, 32'h0, 32'h000080FF, 1'b0);
        xact(1'b0, DIGIT_H, 1'b1, 32'h20, 32'h0, 32'h00007F01, 1'b0);
        xact(1'b0, DIGIT_B, 1'b1, 32'h21, 32'h0, 32'h0000007F, 1'b0);
        xact(1'b0, DIGIT_W, 1'b1, 32'h20, 32'h0, 32'h80FF7F01, 1'b0);
        xact(1'b1, DIGIT_W, 1'b0, 32'h30, 32'h11223344, 32'h0, 1'b0);
        xact(1'b1, DIGIT_B, 1'b0, 32'h31, 32'hFFFFFFAB, 32'h0, 1'b0);
        xact(1'b0, DIGIT_W, 1'b0, 32'h30, 32'h0, 32'h1122AB44, 1'b0);
        xact(1'b1, DIGIT_W, 1'b0, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
        xact(1'b1, DIGIT_H, 1'b0, 32'h31, 32'hFFFFFFFF, 32'h0, 1'b1);
        xact(1'b1, DIGIT_W, 1'b0, 32'h32, 32'hFFFFFFFF, 32'h0, 1'b1);
        xact(1'b1, 2'b11, 1'b0, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1);
        xact(1'b1, DIGIT_W, 1'b0, 32'(4 * DEPTH), 32'hFFFFFFFF, 32'h0, 1'b1);
        xact(1'b0, DIGIT_W, 1'b0, 32'h32, 32'h0, 32'h0, 1'b1);
        xact(1'b0, DIGIT_H, 1'b1, 32'(4 * DEPTH + 2), 32'h0, 32'h0, 1'b1);
        xact(1'b0, DIGIT_W, 1'b0, 32'h30, 32'h0, 32'h1122AB44, 1'b0);
        xact(1'b0, DIGIT_W, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
        log_q.delete();
        issue(1'b1, DIGIT_W, 1'b0, 32'h50, 32'h0A0B0C0D);
        issue(1'b0, DIGIT_B, 1'b0, 32'h51, 32'h0);
        issue(1'b1, DIGIT_H, 1'b0, 32'h52, 32'hFFFF1234);
        issue(1'b0, DIGIT_W, 1'b0, 32'h50, 32'h0);
        bus.req_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("b2b_count", 32'(log_q.size()), 32'd4);
        if (log_q.size() == 4) begin
            chk("b2b_r0", log_q[0][31:0], 32'h0);
            chk("b2b_r1", log_q[1][31:0], 32'h0000000C);
            chk("b2b_r2", log_q[2][31:0], 32'h0);
            chk("b2b_r3", log_q[3][31:0], 32'h12340C0D);
            chk("b2b_err", 32'(log_q[0][32] | log_q[1][32] | log_q[2][32] | log_q[3][32]), 32'd0);
        end
        xact(1'b1, DIGIT_W, 1'b0, 32'h40, 32'h01020304, 32'h0, 1'b0);
        log_q.delete();
        issue(1'b1, DIGIT_W, 1'b0, 32'h40, 32'h55);
        bus.req_valid = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_resp", 32'(log_q.size()), 32'd0);
        xact(1'b0, DIGIT_W, 1'b0, 32'h40, 32'h0, 32'h01020304, 1'b0);
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
